id_hazard_controller: RTL and testbench

- Hazard and forwarding scheduler for the decode (ID) stage.
- Tracks the two instructions issued ahead of the one in ID using a shadow issue pipeline of destination/type info.
- Drives the ID operand/branch/JR forwarding selects (Branch_JR_select_A_FU/B_FU) and requests decode stalls on load-use hazards.
- Sits beside ID; its stall request feeds the Fetch freeze path (OR-ed with ID's WANT_FREEZE).

---
 rtl/id_hazard_controller_pkg.sv | 32 +++
 rtl/id_hazard_controller_fwd_match.sv | 34 +++
 rtl/id_hazard_controller.sv | 112 +++++++++++
 tb/tb_id_hazard_controller.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/id_hazard_controller_pkg.sv
// Shared definitions for the ID-stage hazard controller: forwarding select codes,
// shadow-pipeline slot layouts and the producer/consumer register match helper.
package id_hazard_controller_pkg;

  localparam int NREG_BITS = 5;

  localparam logic [1:0] SEL_REGFILE = 2'd0;
  localparam logic [1:0] SEL_ALU     = 2'd1;
  localparam logic [1:0] SEL_MEM     = 2'd2;

  // Slot for the instruction now in EXE; the ld flag marks data not ready until MEM.
  typedef struct packed {
    logic                 v;
    logic [NREG_BITS-1:0] dest;
    logic                 wr;
    logic                 ld;
  } slot_t;

  // By MEM every producer (load or ALU) has its result, so ld is not kept here.
  typedef struct packed {
    logic                 v;
    logic [NREG_BITS-1:0] dest;
    logic                 wr;
  } mem_slot_t;

  function automatic logic slot_hit(input logic v, input logic wr,
                                    input logic [NREG_BITS-1:0] dest,
                                    input logic [NREG_BITS-1:0] r);
    return v & wr & (dest == r) & (r != '0);
  endfunction

endpackage

// File: rtl/id_hazard_controller_fwd_match.sv
// Per-operand forwarding select and load-use detection against the EXE/MEM slots.
// Youngest producer (EXE slot) wins over the MEM slot.
module id_hazard_controller_fwd_match
  import id_hazard_controller_pkg::*;
(
  input  logic                 i_uses,
  input  logic [NREG_BITS-1:0] i_reg,
  input  slot_t                i_slot1,
  input  mem_slot_t            i_slot2,
  output logic [1:0]           o_sel,
  output logic                 o_ld_hazard
);

  logic w_hit1;
  logic w_hit2;

  assign w_hit1 = slot_hit(i_slot1.v, i_slot1.wr, i_slot1.dest, i_reg);
  assign w_hit2 = slot_hit(i_slot2.v, i_slot2.wr, i_slot2.dest, i_reg);

  // A load in EXE cannot forward yet; the caller stalls on o_ld_hazard instead.
  always_comb begin
    o_sel = SEL_REGFILE;
    if (i_uses) begin
      if (w_hit1 && !i_slot1.ld) begin
        o_sel = SEL_ALU;
      end else if (w_hit2) begin
        o_sel = SEL_MEM;
      end
    end
  end

  assign o_ld_hazard = i_uses & w_hit1 & i_slot1.ld;

endmodule

// File: rtl/id_hazard_controller.sv
// Decode-stage hazard/forwarding scheduler with a two-deep shadow issue pipeline.
// Define HAZARD_PERF_EN to add stall/forwarding performance counters.
module id_hazard_controller
  import id_hazard_controller_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 id_valid,
  input  logic [NREG_BITS-1:0] id_rs,
  input  logic [NREG_BITS-1:0] id_rt,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  input  logic [NREG_BITS-1:0] id_dest,
  input  logic                 id_reg_write,
  input  logic                 id_mem_read,
  input  logic                 freeze_in,
  output logic [1:0]           sel_a,
  output logic [1:0]           sel_b,
  output logic                 stall,
  output logic [2:0]           stall_run
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]          perf_stalls,
  output logic [31:0]          perf_fwd_alu,
  output logic [31:0]          perf_fwd_mem
`endif
);

  slot_t     r_slot1;
  mem_slot_t r_slot2;
  logic [2:0] r_stall_run;
  logic      w_haz_a;
  logic      w_haz_b;

  id_hazard_controller_fwd_match u_match_a (
    .i_uses      (id_uses_rs),
    .i_reg       (id_rs),
    .i_slot1     (r_slot1),
    .i_slot2     (r_slot2),
    .o_sel       (sel_a),
    .o_ld_hazard (w_haz_a)
  );

  id_hazard_controller_fwd_match u_match_b (
    .i_uses      (id_uses_rt),
    .i_reg       (id_rt),
    .i_slot1     (r_slot1),
    .i_slot2     (r_slot2),
    .o_sel       (sel_b),
    .o_ld_hazard (w_haz_b)
  );

  assign stall     = id_valid & (w_haz_a | w_haz_b);
  assign stall_run = r_stall_run;

  // Stall and freeze both just turn the EXE-bound instruction into a single bubble.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_slot1     <= '0;
      r_slot2     <= '0;
      r_stall_run <= '0;
    end else begin
      r_slot2 <= '{v: r_slot1.v, dest: r_slot1.dest, wr: r_slot1.wr};
      if (stall || freeze_in || !id_valid) begin
        r_slot1 <= '0;
      end else begin
        r_slot1 <= '{v: 1'b1, dest: id_dest,
                     wr: id_reg_write & (id_dest != '0), ld: id_mem_read};
      end
      if (!stall) begin
        r_stall_run <= '0;
      end else if (r_stall_run != 3'd7) begin
        r_stall_run <= r_stall_run + 3'd1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_stalls;
  logic [31:0] r_perf_fwd_alu;
  logic [31:0] r_perf_fwd_mem;
  logic        w_count_fwd;

  assign w_count_fwd  = id_valid & !stall & !freeze_in;
  assign perf_stalls  = r_perf_stalls;
  assign perf_fwd_alu = r_perf_fwd_alu;
  assign perf_fwd_mem = r_perf_fwd_mem;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_perf_stalls  <= '0;
      r_perf_fwd_alu <= '0;
      r_perf_fwd_mem <= '0;
    end else begin
      if (stall) begin
        r_perf_stalls <= r_perf_stalls + 32'd1;
      end
      if (w_count_fwd) begin
        r_perf_fwd_alu <= r_perf_fwd_alu + {31'd0, sel_a == SEL_ALU} + {31'd0, sel_b == SEL_ALU};
        r_perf_fwd_mem <= r_perf_fwd_mem + {31'd0, sel_a == SEL_MEM} + {31'd0, sel_b == SEL_MEM};
      end
    end
  end

  always @(posedge CLK) begin
    if (RESET && stall) begin
      $display("load-use stall: rs=%0d rt=%0d slot1.dest=%0d", id_rs, id_rt, r_slot1.dest);
    end
  end
`endif

endmodule

// File: tb/tb_id_hazard_controller.sv
// Directed, table-driven check of the ID hazard controller: forwarding selects,
// load-use stalls, freeze bubbles, register-zero rule and asynchronous reset.
module tb_id_hazard_controller;

  logic       CLK;
  logic       RESET;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic [4:0] id_dest;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       freeze_in;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       stall;
  logic [2:0] stall_run;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dest;
    logic       wr;
    logic       ld;
    logic       frz;
    logic [1:0] ea;
    logic [1:0] eb;
    logic       es;
    logic [2:0] er;
  } vec_t;

  vec_t vecs[$];

  id_hazard_controller dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_dest      (id_dest),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .freeze_in    (freeze_in),
    .sel_a        (sel_a),
    .sel_b        (sel_b),
    .stall        (stall),
    .stall_run    (stall_run)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic vec_t mk(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic [4:0] dest,
                              input logic wr, input logic ld, input logic frz,
                              input logic [1:0] ea, input logic [1:0] eb,
                              input logic es, input logic [2:0] er);
    vec_t v;
    v.valid = valid; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
    v.dest = dest; v.wr = wr; v.ld = ld; v.frz = frz;
    v.ea = ea; v.eb = eb; v.es = es; v.er = er;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    id_valid     = v.valid;
    id_rs        = v.rs;
    id_rt        = v.rt;
    id_uses_rs   = v.urs;
    id_uses_rt   = v.urt;
    id_dest      = v.dest;
    id_reg_write = v.wr;
    id_mem_read  = v.ld;
    freeze_in    = v.frz;
  endtask

  task automatic checkOutput(input string name, input int step,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d got %0d want %0d", name, step, act, exp);
    end
  endtask

  initial begin
    // valid rs rt urs urt dest wr ld frz | sel_a sel_b stall stall_run
    vecs.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0));  // 0 ALU producer dest=5
    vecs.push_back(mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));  // 1 rs=5 from EXE
    vecs.push_back(mk(1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0));  // 2 rt=5 from MEM
    vecs.push_back(mk(1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0));  // 3 load dest=8
    vecs.push_back(mk(1, 8, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0));  // 4 branch rs=8: stall
    vecs.push_back(mk(1, 8, 0, 1, 1, 0, 0, 0, 0, 2, 0, 0, 1));  // 5 retry: MEM forward
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));  // 6 writes r0
    vecs.push_back(mk(1, 0, 0, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0));  // 7 r0 never forwards
    vecs.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0));  // 8 second dest=9
    vecs.push_back(mk(1, 9, 9, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0));  // 9 youngest wins
    vecs.push_back(mk(1, 9, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0));  // 10 older in MEM
    vecs.push_back(mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0));  // 11 dest=4
    vecs.push_back(mk(1, 4, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0));  // 12 freeze 1
    vecs.push_back(mk(1, 4, 0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0));  // 13 freeze 2
    vecs.push_back(mk(1, 4, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));  // 14 freeze 3: slots empty
    vecs.push_back(mk(1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // 15 still empty
    vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0));  // 16 load dest=7
    vecs.push_back(mk(1, 7, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0));  // 17 stall with freeze
    vecs.push_back(mk(1, 7, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 1));  // 18 single bubble
    vecs.push_back(mk(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0, 0));  // 19 load dest=6
    vecs.push_back(mk(0, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // 20 bubble: no stall
    vecs.push_back(mk(1, 6, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0));  // 21 MEM forward
    vecs.push_back(mk(1, 0, 0, 0, 0, 10, 1, 1, 0, 0, 0, 0, 0)); // 22 load dest=10
    vecs.push_back(mk(1, 0, 10, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0)); // 23 store data rt=10
    vecs.push_back(mk(1, 0, 10, 0, 1, 0, 0, 0, 0, 0, 2, 0, 1)); // 24 retry
    vecs.push_back(mk(1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 0, 0, 0)); // 25 dest=11
    vecs.push_back(mk(1, 11, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));// 26 operand unused

    // Reset with a would-be consumer on the inputs.
    RESET = 1'b0;
    applyStimulus(mk(1, 3, 3, 1, 1, 3, 1, 1, 0, 0, 0, 0, 0));
    #12;
    checkOutput("reset_sel_a", -1, 32'(sel_a), 32'd0);
    checkOutput("reset_sel_b", -1, 32'(sel_b), 32'd0);
    checkOutput("reset_stall", -1, 32'(stall), 32'd0);
    checkOutput("reset_run", -1, 32'(stall_run), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      applyStimulus(vecs[i]);
      #4;
      checkOutput("sel_a", i, 32'(sel_a), 32'(vecs[i].ea));
      checkOutput("sel_b", i, 32'(sel_b), 32'(vecs[i].eb));
      checkOutput("stall", i, 32'(stall), 32'(vecs[i].es));
      checkOutput("stall_run", i, 32'(stall_run), 32'(vecs[i].er));
    end

    // Asynchronous reset in the middle of a load-use stall.
    @(negedge CLK);
    applyStimulus(mk(1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 0, 0, 0));
    @(negedge CLK);
    applyStimulus(mk(1, 12, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    checkOutput("midstall_pre", 100, 32'(stall), 32'd1);
    RESET = 1'b0;
    #1;
    checkOutput("midstall_stall", 100, 32'(stall), 32'd0);
    checkOutput("midstall_sel_a", 100, 32'(sel_a), 32'd0);
    checkOutput("midstall_run", 100, 32'(stall_run), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    #4;
    checkOutput("post_reset_stall", 101, 32'(stall), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
